// File: rtl/board_shuffler_pkg.sv
// ---------------------------------------------------------------------------
// board_shuffler_pkg
//
// Shared definitions for the board shuffler and its swap-index helper:
//   - default tile count and tile value width
//   - index width derived from the default tile count
//   - width of the random slice used for index scaling
//   - FSM state encoding
//   - idxWidth(): index width for any legal tile count (4, 8 or 16)
// ---------------------------------------------------------------------------
package board_shuffler_pkg;

    localparam int N_TILES_DEFAULT = 16;
    localparam int VAL_W_DEFAULT   = 4;
    localparam int IDX_W           = $clog2(N_TILES_DEFAULT);

    // Only the low half of the RNG word feeds the index scaler.
    localparam int RNG_W           = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_SWAP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Index width for a board of nTiles tiles; used when the top is
    // parameterised away from the package default.
    function automatic int idxWidth(input int nTiles);
        return $clog2(nTiles);
    endfunction

endpackage

// File: rtl/board_swap_index.sv
// ---------------------------------------------------------------------------
// board_swap_index
//
// Purely combinational helper that picks the swap partner j for one
// Fisher-Yates step. j is the random fraction i_rng/65536 scaled by
// (i_idx+1), i.e. j = (i_rng * (i_idx+1)) >> 16, which always lands in
// 0..i_idx without needing a divider or a modulo.
//
// Ports:
//   i_rng  [RNG_W-1:0]   low 16 bits of the sampled random word
//   i_idx  [IDX_W_P-1:0] current top-of-range index
//   o_j    [IDX_W_P-1:0] swap partner index, 0..i_idx
// ---------------------------------------------------------------------------
module board_swap_index
    import board_shuffler_pkg::*;
#(
    parameter int IDX_W_P = IDX_W
) (
    input  logic [RNG_W-1:0]   i_rng,
    input  logic [IDX_W_P-1:0] i_idx,
    output logic [IDX_W_P-1:0] o_j
);

    logic [IDX_W_P:0]       w_span;
    logic [RNG_W+IDX_W_P:0] w_product;
    logic                   w_unusedBits;

    // idx+1 needs one extra bit: for 16 tiles it reaches 16.
    assign w_span    = {1'b0, i_idx} + (IDX_W_P + 1)'(1);

    // Unsigned 16 x (IDX_W+1) product, both operands zero-extended to the
    // full product width so no bits are lost.
    assign w_product = {{(IDX_W_P + 1){1'b0}}, i_rng} *
                       {{RNG_W{1'b0}}, w_span};

    // The integer part of the scaled fraction is the index. Its top bit is
    // always zero because the result never exceeds i_idx.
    assign o_j       = w_product[RNG_W +: IDX_W_P];

    // Fractional bits and the always-zero top bit are intentionally dropped.
    assign w_unusedBits = ^{w_product[RNG_W-1:0], w_product[RNG_W+IDX_W_P]};

endmodule

// File: rtl/board_shuffler.sv
// ---------------------------------------------------------------------------
// board_shuffler
//
// Deals a shuffled memory-game board: N_TILES tiles holding the values
// 0..N_TILES/2-1, each value exactly twice. A start pulse loads the sorted
// pair board 0,0,1,1,... and then runs a Fisher-Yates shuffle from the top
// index down to 1, requesting a fresh random word from an external RNG for
// every swap step.
//
// Each swap step takes three cycles: REQ raises rng_req, WAIT gives the RNG
// a cycle to produce the new word (sampled at the end of WAIT), SWAP
// exchanges tile[idx] with tile[j]. This spacing keeps rng_req pulses one
// cycle wide with two low cycles between them.
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous, active-high reset
//   start    single-cycle request to deal a new board (IDLE only)
//   rng_num  [31:0] current random word; only bits [15:0] are used
//   rng_req  registered pulse to the RNG, one per swap step
//   busy     high from INIT through the last SWAP
//   done     registered one-cycle pulse when the board is final
//   board    [N_TILES*VAL_W-1:0] tile i at bits [VAL_W*i +: VAL_W]
//
// Legal tile counts are 4, 8 and 16.
// ---------------------------------------------------------------------------
module board_shuffler
    import board_shuffler_pkg::*;
#(
    parameter int N_TILES = N_TILES_DEFAULT,
    parameter int VAL_W   = VAL_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              rng_num,
    output logic                     rng_req,
    output logic                     busy,
    output logic                     done,
    output logic [N_TILES*VAL_W-1:0] board
);

    localparam int TILE_IDX_W = idxWidth(N_TILES);

    state_t                r_state;
    state_t                w_nextState;

    logic [TILE_IDX_W-1:0] r_idx;
    logic [RNG_W-1:0]      r_rngSample;
    logic [VAL_W-1:0]      r_tiles [N_TILES];

    logic                  r_busy;
    logic                  r_done;
    logic                  r_rngReq;

    logic [TILE_IDX_W-1:0] w_swapIdx;
    logic                  w_unusedRngHi;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so re-pulsing it
    // during a shuffle has no effect.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_INIT;
                end
            end
            S_INIT: w_nextState = S_REQ;
            S_REQ:  w_nextState = S_WAIT;
            S_WAIT: w_nextState = S_SWAP;
            S_SWAP: begin
                if (r_idx == TILE_IDX_W'(1)) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextState = S_REQ;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so each one is
    // glitch-free and aligned with the state it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rngReq <= 1'b0;
        end else begin
            r_busy   <= (w_nextState != S_IDLE) && (w_nextState != S_DONE);
            r_done   <= (w_nextState == S_DONE);
            r_rngReq <= (w_nextState == S_REQ);
        end
    end

    // Swap partner for the current step, computed from the word captured at
    // the end of WAIT.
    board_swap_index #(
        .IDX_W_P (TILE_IDX_W)
    ) u_swapIndex (
        .i_rng (r_rngSample),
        .i_idx (r_idx),
        .o_j   (w_swapIdx)
    );

    // Board datapath. The tiles change only in INIT (load the sorted pair
    // board) and SWAP (exchange two tiles). When j equals idx both writes
    // carry the same value, so the board is left unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_rngSample <= '0;
            for (int i = 0; i < N_TILES; i++) begin
                r_tiles[i] <= '0;
            end
        end else begin
            case (r_state)
                S_INIT: begin
                    for (int i = 0; i < N_TILES; i++) begin
                        r_tiles[i] <= VAL_W'(i >> 1);
                    end
                    r_idx <= TILE_IDX_W'(N_TILES - 1);
                end
                S_WAIT: begin
                    r_rngSample <= rng_num[RNG_W-1:0];
                end
                S_SWAP: begin
                    r_tiles[r_idx]     <= r_tiles[w_swapIdx];
                    r_tiles[w_swapIdx] <= r_tiles[r_idx];
                    if (r_idx != TILE_IDX_W'(1)) begin
                        r_idx <= r_idx - TILE_IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the tile registers onto the board port, tile 0 in the LSBs.
    for (genvar g = 0; g < N_TILES; g++) begin : g_board
        assign board[VAL_W*g +: VAL_W] = r_tiles[g];
    end

    // The upper half of the RNG word is not needed for index scaling.
    assign w_unusedRngHi = ^rng_num[31:RNG_W];

    assign rng_req = r_rngReq;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_board_shuffler.sv
// ---------------------------------------------------------------------------
// tb_board_shuffler
//
// Self-checking bench for board_shuffler (16 tiles, 4-bit values).
// Expected final boards are pushed onto a scoreboard queue when a shuffle is
// started and popped when done is seen. Random boards are predicted from a
// xorshift32 RNG model that advances on every rng_req pulse.
// Cycle numbering: cycle 1 is the cycle following the edge that samples
// start; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_board_shuffler;

    localparam int NT = 16;
    localparam int VW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [31:0]    rng_num;
    logic           rng_req;
    logic           busy;
    logic           done;
    logic [NT*VW-1:0] board;

    logic           useLiveRng = 1'b0;
    logic [31:0]    rngConst   = 32'h0000_FFFF;
    logic [31:0]    rngLive    = 32'hACE1_2468;

    int             nChecks = 0;
    int             nFails  = 0;
    logic [63:0]    expQ [$];

    board_shuffler #(
        .N_TILES (NT),
        .VAL_W   (VW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rng_num (rng_num),
        .rng_req (rng_req),
        .busy    (busy),
        .done    (done),
        .board   (board)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // RNG stage model: a new word appears after each rng_req pulse.
    always @(posedge clk) begin
        if (useLiveRng && rng_req) begin
            rngLive <= xorshift32(rngLive);
        end
    end

    assign rng_num = useLiveRng ? rngLive : rngConst;

    // Predicts the final board for a shuffle driven by the live RNG whose
    // current state is seed.
    function automatic logic [63:0] predictBoard(input logic [31:0] seed);
        logic [3:0]  t [NT];
        logic [3:0]  tmp;
        logic [31:0] r;
        logic [63:0] res;
        int          j;
        r = seed;
        for (int i = 0; i < NT; i++) t[i] = 4'(i / 2);
        for (int idx = NT - 1; idx >= 1; idx--) begin
            r   = xorshift32(r);
            j   = int'((32'(r[15:0]) * 32'(idx + 1)) >> 16);
            tmp    = t[idx];
            t[idx] = t[j];
            t[j]   = tmp;
        end
        res = '0;
        for (int i = 0; i < NT; i++) res[4*i +: 4] = t[i];
        return res;
    endfunction

    // True when every value 0..7 appears exactly twice and no tile uses
    // its upper bit.
    function automatic bit pairsOk(input logic [63:0] b);
        int         cnt [8];
        logic [3:0] v;
        bit         ok;
        ok = 1'b1;
        for (int k = 0; k < 8; k++) cnt[k] = 0;
        for (int i = 0; i < NT; i++) begin
            v = b[4*i +: 4];
            if (v > 4'd7) ok = 1'b0;
            else cnt[v[2:0]]++;
        end
        for (int k = 0; k < 8; k++) if (cnt[k] != 2) ok = 1'b0;
        return ok;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    // Runs one shuffle whose final board is expBoard, optionally re-pulsing
    // start at cycles extra1/extra2 (0 = none), and checks timing, rng_req
    // pulses, busy, the pair invariant, the final board and the idle hold.
    task automatic applyStimulus(input logic [63:0] expBoard, input int extra1,
                                 input int extra2);
        logic [63:0] sbBoard;
        int doneCycle, reqCount, minGap, lastReq, busyBad, invBad;
        expQ.push_back(expBoard);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        doneCycle = 0; reqCount = 0; minGap = 1000; lastReq = -100;
        busyBad = 0; invBad = 0;
        for (int c = 1; c <= 80 && doneCycle == 0; c++) begin
            @(negedge clk);
            start = (c == extra1) || (c == extra2);
            if (rng_req) begin
                reqCount++;
                if (c - lastReq < minGap) minGap = c - lastReq;
                lastReq = c;
            end
            if (done) doneCycle = c;
            else if (!busy) busyBad++;
            if (c >= 2 && !pairsOk(board)) invBad++;
        end
        start = 1'b0;
        checkOutput("doneCycle", 64'(doneCycle), 64'd47);
        checkOutput("rngReqCount", 64'(reqCount), 64'd15);
        checkOutput("rngReqGap", 64'(minGap >= 3), 64'd1);
        checkOutput("busyWhileRunning", 64'(busyBad), 64'd0);
        checkOutput("pairInvariant", 64'(invBad), 64'd0);
        if (expQ.size() > 0) begin
            sbBoard = expQ.pop_front();
            if (doneCycle != 0) begin
                checkOutput("busyAtDone", 64'(busy), 64'd0);
                checkOutput("finalBoard", board, sbBoard);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("idleDone", 64'(done), 64'd0);
            checkOutput("idleBusy", 64'(busy), 64'd0);
            checkOutput("idleBoardHold", board, expBoard);
        end
    endtask

    initial begin
        int strays;

        // Reset state.
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resetBoard", board, 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetDone", 64'(done), 64'd0);
        checkOutput("resetRngReq", 64'(rng_req), 64'd0);

        // start and reset high together: start must be discarded.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        strays = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || rng_req || done) strays++;
        end
        checkOutput("startUnderReset", 64'(strays), 64'd0);
        checkOutput("boardAfterReset", board, 64'd0);

        // Held 0xFFFF: every j equals idx, the sorted board survives.
        useLiveRng = 1'b0;
        rngConst   = 32'h0000_FFFF;
        applyStimulus(64'h7766_5544_3322_1100, 0, 0);

        // Held 0: every j is 0, giving 0,1,1,2,...,7,7,0.
        rngConst = 32'h0000_0000;
        applyStimulus(64'h0776_6554_4332_2110, 0, 0);

        // Upper RNG bits must be ignored.
        rngConst = 32'hFFFF_0000;
        applyStimulus(64'h0776_6554_4332_2110, 0, 0);

        // Live RNG with start re-pulsed mid-shuffle.
        useLiveRng = 1'b1;
        applyStimulus(predictBoard(rngLive), 5, 30);

        // Reset at cycle 20 abandons the shuffle.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        checkOutput("midResetBoard", board, 64'd0);
        checkOutput("midResetBusy", 64'(busy), 64'd0);
        checkOutput("midResetDone", 64'(done), 64'd0);
        checkOutput("midResetRngReq", 64'(rng_req), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        strays = 0;
        repeat (60) begin
            @(negedge clk);
            if (done || rng_req || busy) strays++;
        end
        checkOutput("afterAbort", 64'(strays), 64'd0);
        applyStimulus(predictBoard(rngLive), 0, 0);

        // 100 shuffles from the live RNG.
        for (int k = 0; k < 100; k++) begin
            applyStimulus(predictBoard(rngLive), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/board_shuffler.md
BOARD_SHUFFLER -- requirements
Module: board_shuffler

Interface
REQ-001 Parameter: N_TILES, 16, tile count; legal values 4, 8, 16.
REQ-002 Parameter: VAL_W, 4, bits per tile value.
REQ-003 Port: clk  input  1  clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  single-cycle request to deal a new shuffled board.
REQ-006 Port: rng_num  input  32  current random word from the RNG stage.
REQ-007 Port: rng_req  output  1  registered pulse to the RNG changeNum input, one per swap step.
REQ-008 Port: busy  output  1  high from the first cycle after start is accepted until done.
REQ-009 Port: done  output  1  registered one-cycle pulse when the board is final.
REQ-010 Port: board  output  N_TILES*VAL_W  tile i at bits [VAL_W*i+VAL_W-1 : VAL_W*i].

Function
REQ-011 States: IDLE, INIT, REQ, WAIT, SWAP, DONE; IDLE is the only state that accepts start.
REQ-012 IDLE: start=1 -> INIT; start is ignored in every other state.
REQ-013 INIT (1 cycle): tile[i] <= i>>1 for all i (pairs 0,0,1,1,...), idx <= N_TILES-1 -> REQ.
REQ-014 REQ (1 cycle): rng_req=1 -> WAIT.
REQ-015 WAIT (1 cycle): rng_req=0; rng_num is sampled at the end of WAIT -> SWAP.
REQ-016 SWAP (1 cycle): j = (rng_num[15:0] * (idx+1)) >> 16, giving 0..idx with no divider; tile[idx] and tile[j] are swapped in the same edge; j==idx leaves the board unchanged.
REQ-017 SWAP exit: idx==1 -> DONE; otherwise idx <= idx-1 -> REQ.
REQ-018 DONE (1 cycle): done=1, busy=0 -> IDLE.
REQ-019 Latency: done is high exactly 3*(N_TILES-1)+2 cycles after the edge that samples start; this is 47 cycles for N_TILES=16.
REQ-020 rng_req pulses exactly N_TILES-1 times per shuffle, each one cycle wide and separated by at least 2 low cycles, so an edge-triggered RNG sees every pulse.
REQ-021 board holds its value while in IDLE, including after done; it changes only in INIT and SWAP.
REQ-022 Invariant: every value 0..N_TILES/2-1 appears exactly twice on board at every cycle after INIT.
REQ-023 Tile values occupy the low bits of each VAL_W slot; unused upper bits are 0.
REQ-024 Arithmetic: the product is 16x5 bits and unsigned; only rng_num[15:0] is used.

Reset
REQ-025 reset=1 forces IDLE, idx=0, board=0, busy=0, done=0, rng_req=0 immediately, independent of clk.
REQ-026 Reset mid-shuffle abandons the shuffle; no done pulse and no further rng_req pulses occur.
REQ-027 When reset and start are high in the same cycle, reset wins and start is discarded.
REQ-028 After reset deasserts, the first start is accepted normally.

Structure
REQ-029 Shared package holds: the N_TILES default, VAL_W, the state encoding constants, and IDX_W = clog2(N_TILES).
REQ-030 One combinational sub-module, board_swap_index, computes j from rng_num[15:0] and idx; all registers stay in board_shuffler.
REQ-031 The board is a register array flattened onto the board port; there is no RAM inference.

Verification
REQ-032 rng_num held at 32'h0000FFFF, start pulse -> identity board 0,0,1,1,...,7,7; done at cycle 47; exactly 15 rng_req pulses.
REQ-033 rng_num held at 0, start pulse -> tiles 0..15 = 0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,0.
REQ-034 Connected to the RNG stage, 100 start pulses -> every final board has each value 0..7 exactly twice, and busy/done timing matches REQ-019.
REQ-035 reset asserted at cycle 20 of a shuffle -> board=0, busy=0 at once; no done pulse; next start completes normally.
REQ-036 start re-pulsed at cycles 5 and 30 of a shuffle -> ignored; a single done pulse at cycle 47.
REQ-037 start and reset high together -> module stays IDLE and rng_req stays 0.
